adder_serial_chunked: RTL and testbench

- Parametrised multi-cycle adder that sums two WIDTH-bit operands CHUNK bits per clock, rippling the carry through a register between chunks.
- Successor to the fixed-width combinational ripple adders in the adder-comparison family. It trades latency for area and sits behind a valid/ready handshake on both sides.
- Used as the area-minimal sequential data point in architecture comparisons.

---
 rtl/adder_serial_chunked.sv | 147 ++++++++++++++
 tb/tb_adder_serial_chunked.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_serial_chunked.sv
// ---------------------------------------------------------------------------
// adder_serial_chunked
//
// Multi-cycle adder. It sums two WIDTH-bit operands CHUNK bits per clock and
// carries between chunks through a one-bit register. Operands are accepted
// over a valid/ready handshake. The result is offered over a second
// valid/ready handshake and is held until downstream accepts it.
//
// Parameters:
//   WIDTH  operand and sum width (>= 1, multiple of CHUNK)
//   CHUNK  bits added per cycle (1 .. WIDTH)
//
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low reset
//   valid_i  operands valid           ready_o  block idle, operands accepted
//   A_i,B_i  operands                 cin_i    carry in
//   valid_o  result valid             ready_i  downstream takes result
//   SUM_o    registered sum           cout_o   registered final carry out
//
// Optional feature (macro ADDER_SERIAL_SUB_EN):
//   Adds input sub_i, captured together with the operands. When sub_i=1 the
//   block computes A + ~B + 1 and ignores cin_i. cout_o=1 then means no
//   borrow.
// ---------------------------------------------------------------------------
module adder_serial_chunked #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             cin_i,
`ifdef ADDER_SERIAL_SUB_EN
  input  logic             sub_i,
`endif
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] SUM_o,
  output logic             cout_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;

  // Operands and sum are stored as CHUNK-wide slices, so the active chunk
  // can be selected directly by the counter.
  logic [NCHUNK-1:0][CHUNK-1:0] a_q, a_d;
  logic [NCHUNK-1:0][CHUNK-1:0] b_q, b_d;
  logic [NCHUNK-1:0][CHUNK-1:0] sum_q, sum_d;
  logic                         carry_q, carry_d;
  logic                         cout_q, cout_d;
  logic [CW-1:0]                cnt_q, cnt_d;

  logic [CHUNK:0] chunk_sum;
  logic           b_inv;
  logic           cin_eff;

  // Subtraction is a + ~b + 1. B is inverted and the carry is forced at
  // capture, so the BUSY datapath is the same for add and subtract.
`ifdef ADDER_SERIAL_SUB_EN
  assign b_inv   = sub_i;
  assign cin_eff = sub_i ? 1'b1 : cin_i;
`else
  assign b_inv   = 1'b0;
  assign cin_eff = cin_i;
`endif

  assign chunk_sum = {1'b0, a_q[cnt_q]} + {1'b0, b_q[cnt_q]}
                   + {{CHUNK{1'b0}}, carry_q};

  // NOTE: every signal driven here first receives its default (hold)
  // value. A path that leaves a signal unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_d     = A_i;
          b_d     = B_i ^ {WIDTH{b_inv}};
          carry_d = cin_eff;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[cnt_q] = chunk_sum[CHUNK-1:0];
        carry_d      = chunk_sum[CHUNK];
        if (cnt_q == LAST) begin
          cout_d  = chunk_sum[CHUNK];
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples pre-edge values, whatever order they are
  // written in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign SUM_o   = sum_q;
  assign cout_o  = cout_q;

endmodule

// File: tb/tb_adder_serial_chunked.sv
// ---------------------------------------------------------------------------
// tb_adder_serial_chunked
//
// Directed self-checking bench for adder_serial_chunked. It drives two
// instances: WIDTH=32/CHUNK=8 (four chunks) and WIDTH=32/CHUNK=32 (single
// chunk). It covers reset values, a table of add vectors with latency
// checks, back-pressure hold, reset in the middle of BUSY, and subtraction
// when ADDER_SERIAL_SUB_EN is defined.
// ---------------------------------------------------------------------------
module tb_adder_serial_chunked;

  logic        clk = 1'b0;
  logic        rst_n;

  // Four-chunk instance.
  logic        valid_in, ready_out, cin, valid_out, ready_in, cout;
  logic [31:0] a, b, sum;
  logic        sub;

  // Single-chunk instance.
  logic        valid_in1, ready_out1, cin1, valid_out1, ready_in1, cout1;
  logic [31:0] a1, b1, sum1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_serial_chunked #(.WIDTH(32), .CHUNK(8)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (valid_in),
    .ready_o (ready_out),
    .A_i     (a),
    .B_i     (b),
    .cin_i   (cin),
`ifdef ADDER_SERIAL_SUB_EN
    .sub_i   (sub),
`endif
    .valid_o (valid_out),
    .ready_i (ready_in),
    .SUM_o   (sum),
    .cout_o  (cout)
  );

  adder_serial_chunked #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (valid_in1),
    .ready_o (ready_out1),
    .A_i     (a1),
    .B_i     (b1),
    .cin_i   (cin1),
`ifdef ADDER_SERIAL_SUB_EN
    .sub_i   (1'b0),
`endif
    .valid_o (valid_out1),
    .ready_i (ready_in1),
    .SUM_o   (sum1),
    .cout_o  (cout1)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One transaction on the four-chunk instance, up to (not including)
  // result release. lat counts edges after the accept edge until valid_o.
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic op_cin, input logic op_sub,
                        output logic [31:0] r_sum, output logic r_cout,
                        output int lat);
    @(negedge clk);
    a = op_a; b = op_b; cin = op_cin; sub = op_sub;
    valid_in = 1'b1; ready_in = 1'b0;
    @(posedge clk);
    #1 valid_in = 1'b0;
    lat = 0;
    while (!valid_out && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    r_sum  = sum;
    r_cout = cout;
  endtask

  task automatic release_result();
    @(negedge clk);
    ready_in = 1'b1;
    @(posedge clk);
    #1 ready_in = 1'b0;
  endtask

  initial begin
    logic [31:0] r_sum, held_sum;
    logic        r_cout, held_cout;
    int          lat;

    rst_n = 1'b0;
    valid_in = 1'b0; ready_in = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    valid_in1 = 1'b0; ready_in1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

    vecs.push_back('{32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0});
    vecs.push_back('{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0});
    vecs.push_back('{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0});
`ifdef ADDER_SERIAL_SUB_EN
    vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1});
`endif

    // Reset values.
    #12;
    check("rst_ready", ready_out, 1);
    check("rst_valid", valid_out, 0);
    check("rst_sum",   sum,       0);
    check("rst_cout",  cout,      0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of vectors, four-chunk instance.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, r_sum, r_cout, lat);
      check($sformatf("vec%0d_sum", i),  r_sum,  vecs[i].exp_sum);
      check($sformatf("vec%0d_cout", i), r_cout, vecs[i].exp_cout);
      check($sformatf("vec%0d_lat", i),  lat,    4);
      release_result();
      check($sformatf("vec%0d_idle", i), ready_out, 1);
    end

    // Back-pressure: hold the result while new operands are offered.
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, held_sum, held_cout, lat);
    check("hold_first_sum", held_sum, 32'h0000_0000);
    check("hold_first_cout", held_cout, 1);
    @(negedge clk);
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; valid_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_sum", k),   sum,       32'h0000_0000);
      check($sformatf("hold%0d_cout", k),  cout,      1);
      check($sformatf("hold%0d_valid", k), valid_out, 1);
      check($sformatf("hold%0d_ready", k), ready_out, 0);
    end
    @(negedge clk);
    ready_in = 1'b1; valid_in = 1'b0;
    @(posedge clk);
    #1 ready_in = 1'b0;
    check("release_valid", valid_out, 0);
    check("release_ready", ready_out, 1);
    check("release_sum_kept", sum, 32'h0000_0000);
    check("release_cout_kept", cout, 1);
    // No operation was captured during the hold, so the block stays idle.
    repeat (6) @(posedge clk);
    #1 check("no_capture_valid", valid_out, 0);
    check("no_capture_sum", sum, 32'h0000_0000);

    // Reset two cycles into BUSY. Operands make the partial sum nonzero.
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("busy_partial_sum", sum, 32'h0000_FFFF);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", valid_out, 0);
    check("midrst_ready", ready_out, 1);
    check("midrst_sum",   sum,       0);
    check("midrst_cout",  cout,      0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, r_sum, r_cout, lat);
    check("postrst_sum",  r_sum,  32'h0000_0030);
    check("postrst_cout", r_cout, 0);
    check("postrst_lat",  lat,    4);
    release_result();

    // Single-chunk instance: latency of one cycle.
    for (int v = 0; v < 2; v++) begin
      logic [31:0] ea;
      logic [31:0] eb;
      logic [31:0] es;
      logic        ec;
      if (v == 0) begin
        ea = 32'h8000_0000; eb = 32'h8000_0000; es = 32'h0000_0001; ec = 1'b1;
      end else begin
        ea = 32'hFFFF_FFFF; eb = 32'h0000_0000; es = 32'h0000_0000; ec = 1'b1;
      end
      @(negedge clk);
      a1 = ea; b1 = eb; cin1 = 1'b1; valid_in1 = 1'b1;
      @(posedge clk);
      #1 valid_in1 = 1'b0;
      lat = 0;
      while (!valid_out1 && lat < 20) begin
        @(posedge clk);
        #1 lat++;
      end
      check($sformatf("c32_%0d_sum", v),  sum1,  es);
      check($sformatf("c32_%0d_cout", v), cout1, ec);
      check($sformatf("c32_%0d_lat", v),  lat,   1);
      @(negedge clk);
      ready_in1 = 1'b1;
      @(posedge clk);
      #1 ready_in1 = 1'b0;
      check($sformatf("c32_%0d_idle", v), ready_out1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
